// File: rtl/spi_2ph_multi_tx_pkg.sv
// Shared definitions for the two-phase multi-lane serial transmitter:
// FSM and phase encodings plus default parameter values.
package spi_2ph_multi_tx_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_NUM_CH     = 2;
    localparam int DEF_DIV_WIDTH  = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_LATCH = 2'b10
    } state_t;

    // P0 setup, P1 SCLK1 high, P2 gap, P3 SCLK2 high
    typedef enum logic [1:0] {
        PH_P0 = 2'b00,
        PH_P1 = 2'b01,
        PH_P2 = 2'b10,
        PH_P3 = 2'b11
    } phase_t;

endpackage

// File: rtl/spi_2ph_multi_tx_phase_tick.sv
// Phase-length divider: counts clock cycles against the captured divide value
// and emits a one-cycle tick on the last cycle of every phase.
module spi_2ph_multi_tx_phase_tick
    import spi_2ph_multi_tx_pkg::*;
#(
    parameter int DIV_WIDTH = DEF_DIV_WIDTH
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_clear,
    input  logic                 i_run,
    input  logic [DIV_WIDTH-1:0] i_div,
    output logic                 o_tick
);

    logic [DIV_WIDTH-1:0] r_cnt;

    assign o_tick = i_run && (r_cnt == i_div);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clear || o_tick) begin
            r_cnt <= '0;
        end else if (i_run) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/spi_2ph_multi_tx.sv
// Multi-lane serial transmitter with two non-overlapping shift clocks and a
// latch strobe; every lane shares SCLK1/SCLK2/LAT and has its own data line.
module spi_2ph_multi_tx
    import spi_2ph_multi_tx_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_CH     = DEF_NUM_CH,
    parameter int DIV_WIDTH  = DEF_DIV_WIDTH
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_bgn,
    input  logic [DATA_WIDTH*NUM_CH-1:0] i_din,
    input  logic [NUM_CH-1:0]            i_ch_en,
    input  logic [DIV_WIDTH-1:0]         i_div,
    input  logic                         i_lsb_first,
    output logic                         o_rdy,
    output logic                         o_done,
    output logic                         o_sclk1,
    output logic                         o_sclk2,
    output logic                         o_lat,
    output logic [NUM_CH-1:0]            o_spi_so
);

    localparam int BIT_W = $clog2(DATA_WIDTH);

    state_t                  r_state;
    phase_t                  r_phase;
    logic [BIT_W-1:0]        r_bit_cnt;
    logic [DIV_WIDTH-1:0]    r_div;
    logic [NUM_CH-1:0]       r_ch_en;
    logic                    r_lsb_first;
    logic [DATA_WIDTH-1:0]   r_sr [NUM_CH];

    logic                    w_start;
    logic                    w_phase_end;
    logic                    w_last_bit;
    logic [NUM_CH-1:0]       w_first_bit;
    logic [NUM_CH-1:0]       w_next_bit;
    logic [DATA_WIDTH-1:0]   w_sr_shifted [NUM_CH];

    assign w_start    = (r_state == ST_IDLE) && i_bgn;
    assign w_last_bit = (r_bit_cnt == BIT_W'(DATA_WIDTH - 1));

    spi_2ph_multi_tx_phase_tick #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_spi_phase_tick (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clear (w_start),
        .i_run   (r_state != ST_IDLE),
        .i_div   (r_div),
        .o_tick  (w_phase_end)
    );

    // The bit shown next is taken from the already-shifted word so that
    // SPI_SO and the shift register update on the same edge.
    for (genvar gLane = 0; gLane < NUM_CH; gLane++) begin : g_lane
        assign w_first_bit[gLane]  = i_lsb_first ? i_din[gLane*DATA_WIDTH]
                                                 : i_din[gLane*DATA_WIDTH + DATA_WIDTH - 1];
        assign w_sr_shifted[gLane] = r_lsb_first ? (r_sr[gLane] >> 1) : (r_sr[gLane] << 1);
        assign w_next_bit[gLane]   = r_lsb_first ? r_sr[gLane][1] : r_sr[gLane][DATA_WIDTH-2];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_phase     <= PH_P0;
            r_bit_cnt   <= '0;
            r_div       <= '0;
            r_ch_en     <= '0;
            r_lsb_first <= 1'b0;
            for (int k = 0; k < NUM_CH; k++) begin
                r_sr[k] <= '0;
            end
            o_rdy    <= 1'b1;
            o_done   <= 1'b0;
            o_sclk1  <= 1'b0;
            o_sclk2  <= 1'b0;
            o_lat    <= 1'b0;
            o_spi_so <= '0;
        end else begin
            o_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_bgn) begin
                        r_state     <= ST_SHIFT;
                        r_phase     <= PH_P0;
                        r_bit_cnt   <= '0;
                        r_div       <= i_div;
                        r_ch_en     <= i_ch_en;
                        r_lsb_first <= i_lsb_first;
                        o_rdy       <= 1'b0;
                        for (int k = 0; k < NUM_CH; k++) begin
                            r_sr[k]     <= i_din[k*DATA_WIDTH +: DATA_WIDTH];
                            o_spi_so[k] <= w_first_bit[k] & i_ch_en[k];
                        end
                    end
                end
                ST_SHIFT: begin
                    if (w_phase_end) begin
                        case (r_phase)
                            PH_P0: begin
                                r_phase <= PH_P1;
                                o_sclk1 <= 1'b1;
                            end
                            PH_P1: begin
                                r_phase <= PH_P2;
                                o_sclk1 <= 1'b0;
                            end
                            PH_P2: begin
                                r_phase <= PH_P3;
                                o_sclk2 <= 1'b1;
                            end
                            PH_P3: begin
                                r_phase <= PH_P0;
                                o_sclk2 <= 1'b0;
                                if (w_last_bit) begin
                                    r_state  <= ST_LATCH;
                                    o_lat    <= 1'b1;
                                    o_spi_so <= '0;
                                end else begin
                                    r_bit_cnt <= r_bit_cnt + 1'b1;
                                    for (int k = 0; k < NUM_CH; k++) begin
                                        r_sr[k]     <= w_sr_shifted[k];
                                        o_spi_so[k] <= w_next_bit[k] & r_ch_en[k];
                                    end
                                end
                            end
                        endcase
                    end
                end
                ST_LATCH: begin
                    if (w_phase_end) begin
                        r_state <= ST_IDLE;
                        o_lat   <= 1'b0;
                        o_rdy   <= 1'b1;
                        o_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_2ph_multi_tx.sv
// Self-checking bench: table vectors, randomized transfers against a bit-order
// model, and hand sequences for re-pulsed BGN, mid-transfer reset and held BGN.
module tb_spi_2ph_multi_tx;

    localparam int W     = 16;
    localparam int NCH   = 2;
    localparam int DW    = 4;
    localparam int LIMIT = (4*W + 1)*16 + 40;

    logic          i_clk       = 1'b0;
    logic          i_rst_n     = 1'b0;
    logic          i_bgn       = 1'b0;
    logic [31:0]   i_din       = '0;
    logic [1:0]    i_ch_en     = '0;
    logic [3:0]    i_div       = '0;
    logic          i_lsb_first = 1'b0;
    logic          o_rdy, o_done, o_sclk1, o_sclk2, o_lat;
    logic [1:0]    o_spi_so;

    spi_2ph_multi_tx #(
        .DATA_WIDTH (W),
        .NUM_CH     (NCH),
        .DIV_WIDTH  (DW)
    ) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_bgn       (i_bgn),
        .i_din       (i_din),
        .i_ch_en     (i_ch_en),
        .i_div       (i_div),
        .i_lsb_first (i_lsb_first),
        .o_rdy       (o_rdy),
        .o_done      (o_done),
        .o_sclk1     (o_sclk1),
        .o_sclk2     (o_sclk2),
        .o_lat       (o_lat),
        .o_spi_so    (o_spi_so)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [31:0] din;
        logic [1:0]  en;
        logic [3:0]  div;
        logic        lsb;
        logic [15:0] exp1;
        logic [15:0] exp0;
        int          expRdyLow;
        int          expLat;
    } vec_t;

    typedef struct {
        int rdyLow;
        int s1Pulse;
        int s2Pulse;
        int s1High;
        int s2High;
        int latPulse;
        int latHigh;
        int done;
        int doneBad;
        int overlap;
        int stableErr;
        int disErr;
    } cnt_t;

    int          checks = 0;
    int          errors = 0;
    cnt_t        cnt    = '{default: 0};
    cnt_t        snap   = '{default: 0};
    logic [15:0] capWord [2];
    logic [1:0]  firstSo = '0;
    logic [1:0]  enCur   = '0;
    logic        prevRdy = 1'b1;
    logic        prevS1  = 1'b0;
    logic        prevS2  = 1'b0;
    logic        prevLat = 1'b0;
    logic [1:0]  prevSo  = '0;

    // Passive monitor: everything is observed on the falling edge.
    always @(negedge i_clk) begin
        assert (!(o_sclk1 && o_sclk2))
            else $error("[TB] FAIL sclkOverlap sclk1=%b sclk2=%b", o_sclk1, o_sclk2);
        if (o_sclk1 && o_sclk2) cnt.overlap++;
        if (!o_rdy) cnt.rdyLow++;
        if (!o_rdy && prevRdy) firstSo = o_spi_so;
        if (o_sclk1 && !prevS1) begin
            cnt.s1Pulse++;
            for (int k = 0; k < NCH; k++) capWord[k] = {capWord[k][14:0], o_spi_so[k]};
        end
        if (o_sclk1) cnt.s1High++;
        if (o_sclk2 && !prevS2) cnt.s2Pulse++;
        if (o_sclk2) cnt.s2High++;
        if (o_lat && !prevLat) cnt.latPulse++;
        if (o_lat) cnt.latHigh++;
        if (o_done) cnt.done++;
        if (o_done && !o_rdy) cnt.doneBad++;
        if ((o_spi_so != prevSo) && (o_sclk1 || o_sclk2 || prevS1)) cnt.stableErr++;
        if ((o_spi_so & ~enCur) != 2'b00) cnt.disErr++;
        prevRdy = o_rdy;
        prevS1  = o_sclk1;
        prevS2  = o_sclk2;
        prevLat = o_lat;
        prevSo  = o_spi_so;
    end

    function automatic logic [15:0] modelWord(input logic [15:0] d, input logic en, input logic lsb);
        logic [15:0] w;
        w = '0;
        for (int j = 0; j < W; j++) w = {w[14:0], (lsb ? d[j] : d[W-1-j])};
        return en ? w : 16'h0000;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, ".rdy"},   32'(o_rdy),    32'd1);
        checkOutput({tag, ".done"},  32'(o_done),   32'd0);
        checkOutput({tag, ".sclk1"}, 32'(o_sclk1),  32'd0);
        checkOutput({tag, ".sclk2"}, 32'(o_sclk2),  32'd0);
        checkOutput({tag, ".lat"},   32'(o_lat),    32'd0);
        checkOutput({tag, ".so"},    32'(o_spi_so), 32'd0);
    endtask

    task automatic applyStimulus(input vec_t v);
        @(posedge i_clk); #2;
        i_din       = v.din;
        i_ch_en     = v.en;
        i_div       = v.div;
        i_lsb_first = v.lsb;
        enCur       = v.en;
        snap        = cnt;
        i_bgn       = 1'b1;
        @(posedge i_clk); #2;
        i_bgn       = 1'b0;
    endtask

    task automatic waitDone(input string tag, input int rePulseAt);
        bit ok;
        ok = 1'b0;
        for (int c = 1; c < LIMIT; c++) begin
            if (cnt.done != snap.done) begin
                ok = 1'b1;
                break;
            end
            if (c == rePulseAt) begin
                i_bgn       = 1'b1;
                i_din       = ~i_din;
                i_div       = i_div + 4'd1;
                i_lsb_first = ~i_lsb_first;
            end else begin
                i_bgn = 1'b0;
            end
            @(posedge i_clk); #2;
        end
        i_bgn = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL %s.timeout actual=no DONE expected=DONE within %0d cycles", tag, LIMIT);
        end
        repeat (2) @(posedge i_clk);
        #2;
    endtask

    task automatic checkTransfer(input vec_t v, input string tag);
        checkOutput({tag, ".rdyLow"},   32'(cnt.rdyLow - snap.rdyLow),     32'(v.expRdyLow));
        checkOutput({tag, ".s1Pulse"},  32'(cnt.s1Pulse - snap.s1Pulse),   32'(W));
        checkOutput({tag, ".s2Pulse"},  32'(cnt.s2Pulse - snap.s2Pulse),   32'(W));
        checkOutput({tag, ".s1High"},   32'(cnt.s1High - snap.s1High),     32'(W*(int'(v.div)+1)));
        checkOutput({tag, ".s2High"},   32'(cnt.s2High - snap.s2High),     32'(W*(int'(v.div)+1)));
        checkOutput({tag, ".latPulse"}, 32'(cnt.latPulse - snap.latPulse), 32'd1);
        checkOutput({tag, ".latHigh"},  32'(cnt.latHigh - snap.latHigh),   32'(v.expLat));
        checkOutput({tag, ".done"},     32'(cnt.done - snap.done),         32'd1);
        checkOutput({tag, ".doneRdy"},  32'(cnt.doneBad - snap.doneBad),   32'd0);
        checkOutput({tag, ".overlap"},  32'(cnt.overlap - snap.overlap),   32'd0);
        checkOutput({tag, ".stable"},   32'(cnt.stableErr - snap.stableErr), 32'd0);
        checkOutput({tag, ".disabled"}, 32'(cnt.disErr - snap.disErr),     32'd0);
        checkOutput({tag, ".lane1"},    32'(capWord[1]), 32'(v.exp1));
        checkOutput({tag, ".lane0"},    32'(capWord[0]), 32'(v.exp0));
        checkOutput({tag, ".firstBit"}, 32'(firstSo),    32'({v.exp1[15], v.exp0[15]}));
    endtask

    initial begin
        vec_t tbl [5];
        vec_t v;
        bit   ok;

        // {din, en, div, lsb, lane1 bits in send order, lane0 bits, RDY-low cycles, LAT cycles}
        tbl[0] = '{32'hA5C3_0F0F, 2'b11, 4'd0, 1'b0, 16'hA5C3, 16'h0F0F,  65, 1};
        tbl[1] = '{32'hA5C3_0F0F, 2'b11, 4'd3, 1'b0, 16'hA5C3, 16'h0F0F, 260, 4};
        tbl[2] = '{32'hFFFF_0001, 2'b01, 4'd0, 1'b1, 16'h0000, 16'h8000,  65, 1};
        tbl[3] = '{32'h1234_FFFF, 2'b10, 4'd1, 1'b1, 16'h2C48, 16'h0000, 130, 2};
        tbl[4] = '{32'hFFFF_FFFF, 2'b00, 4'd2, 1'b0, 16'h0000, 16'h0000, 195, 3};

        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        checkResetValues("reset");
        @(posedge i_clk); #2;
        i_rst_n = 1'b1;
        repeat (2) @(posedge i_clk);

        for (int i = 0; i < 5; i++) begin
            applyStimulus(tbl[i]);
            waitDone($sformatf("tbl%0d", i), -1);
            checkTransfer(tbl[i], $sformatf("tbl%0d", i));
        end

        applyStimulus(tbl[0]);
        waitDone("repulse", 10);
        checkTransfer(tbl[0], "repulse");

        for (int r = 0; r < 8; r++) begin
            v.din       = $urandom;
            v.en        = 2'($urandom_range(0, 3));
            v.div       = 4'($urandom_range(0, 15));
            v.lsb       = 1'($urandom_range(0, 1));
            v.exp1      = modelWord(v.din[31:16], v.en[1], v.lsb);
            v.exp0      = modelWord(v.din[15:0],  v.en[0], v.lsb);
            v.expRdyLow = (4*W + 1)*(int'(v.div) + 1);
            v.expLat    = int'(v.div) + 1;
            applyStimulus(v);
            waitDone($sformatf("rand%0d", r), -1);
            checkTransfer(v, $sformatf("rand%0d", r));
        end

        // Reset in the middle of a word: outputs clear without waiting for a clock.
        applyStimulus(tbl[0]);
        repeat (19) @(posedge i_clk);
        #3;
        i_rst_n = 1'b0;
        #1;
        checkResetValues("midReset");
        checkOutput("midReset.noLat", 32'(cnt.latPulse - snap.latPulse), 32'd0);
        @(posedge i_clk); #2;
        i_rst_n = 1'b1;
        applyStimulus(tbl[0]);
        waitDone("afterReset", -1);
        checkTransfer(tbl[0], "afterReset");

        // BGN held high: the DONE cycle itself accepts the next request.
        @(posedge i_clk); #2;
        i_din       = tbl[0].din;
        i_ch_en     = tbl[0].en;
        i_div       = tbl[0].div;
        i_lsb_first = tbl[0].lsb;
        enCur       = tbl[0].en;
        snap        = cnt;
        i_bgn       = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < LIMIT; c++) begin
            @(negedge i_clk);
            if (o_done) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL bgnHeld.timeout actual=no DONE expected=DONE within %0d cycles", LIMIT);
        end
        checkOutput("bgnHeld.doneRdy", 32'(o_rdy), 32'd1);
        @(negedge i_clk);
        checkOutput("bgnHeld.restart", 32'(o_rdy), 32'd0);
        i_bgn = 1'b0;
        ok = 1'b0;
        for (int c = 0; c < LIMIT; c++) begin
            @(negedge i_clk);
            if (o_done) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL bgnHeld.timeout2 actual=no DONE expected=DONE within %0d cycles", LIMIT);
        end
        repeat (2) @(negedge i_clk);
        checkOutput("bgnHeld.doneCount", 32'(cnt.done - snap.done),         32'd2);
        checkOutput("bgnHeld.latCount",  32'(cnt.latPulse - snap.latPulse), 32'd2);
        checkOutput("bgnHeld.lane1",     32'(capWord[1]), 32'h0000_A5C3);
        checkOutput("bgnHeld.overlap",   32'(cnt.overlap - snap.overlap),   32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
